// File: rtl/ble_arb_pkg.sv
// Shared types and defaults for the BLE encoder arbiter.
// State encoding, command codes and default bus widths.
package ble_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic [3:0] BLE_CMD_TX = 4'h1;

  localparam int ARB_DATA_W  = 32;
  localparam int ARB_CMD_W   = 4;
  localparam int ARB_ENC_W   = 144;
  localparam int ARB_TMO_CYC = 1024;

  // Counter width able to hold cycles-1.
  function automatic int tmo_w(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: req0/req1/last_grant in,
// grant_valid/grant_idx out (combinational).
module rr_arbiter_2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_idx
);

  assign grant_valid = req0 | req1;

  always_comb begin
    grant_idx = 1'b0;
    unique case (1'b1)
      (req0 & req1):  grant_idx = ~last_grant;
      (req0 & ~req1): grant_idx = 1'b0;
      (~req0 & req1): grant_idx = 1'b1;
      default:        grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/ble_encoder_arbiter.sv
// Shares one bluetooth_encoder between host-rx (req0) and
// device-rx (req1) paths with round-robin arbitration.
// Ports: clk, reset (async, active-low); reqN/reqN_data/
// reqN_cmd in, doneN/rsp_data/rsp_error/busy out; enc_*
// drive/observe the encoder start/done handshake.
// Build option: BLE_ARB_TIMEOUT_EN enables a WAIT-state
// watchdog of TIMEOUT_CYCLES that aborts with rsp_error.
module ble_encoder_arbiter
  import ble_arb_pkg::*;
#(
  parameter int DATA_W         = ARB_DATA_W,
  parameter int CMD_W          = ARB_CMD_W,
  parameter int ENC_W          = ARB_ENC_W,
  parameter int TIMEOUT_CYCLES = ARB_TMO_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [CMD_W-1:0]  req0_cmd,
  input  logic              req1,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [CMD_W-1:0]  req1_cmd,
  output logic              done0,
  output logic              done1,
  output logic [ENC_W-1:0]  rsp_data,
  output logic              rsp_error,
  output logic              busy,
  output logic [DATA_W-1:0] enc_input_data,
  output logic [CMD_W-1:0]  enc_cmd,
  output logic              enc_start,
  input  logic              enc_done,
  input  logic [ENC_W-1:0]  enc_output_data
);

  arb_state_t state;
  arb_state_t state_n;

  logic last_grant;
  logic grant_idx;
  logic arb_valid;
  logic arb_idx;
  logic enc_done_q;
  logic done_rise;
  logic tmo_hit;

  rr_arbiter_2 u_arb (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant),
    .grant_valid (arb_valid),
    .grant_idx   (arb_idx)
  );

  // A done level left over from an earlier job
  // must not complete the current one.
  assign done_rise = enc_done & ~enc_done_q;

`ifdef BLE_ARB_TIMEOUT_EN
  localparam int TW = tmo_w(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;

  // Cleared in START so it reads 0 on the first WAIT cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state == START) begin
      tmo_cnt <= '0;
    end else if (state == WAIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (state == WAIT) && (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (arb_valid) state_n = START;
      START:   state_n = WAIT;
      WAIT:    if (done_rise || tmo_hit) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    enc_start = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE:  busy = 1'b0;
      START: begin
        busy      = 1'b1;
        enc_start = 1'b1;
      end
      WAIT:  busy = 1'b1;
      DONE: begin
        busy  = 1'b1;
        done0 = ~grant_idx;
        done1 = grant_idx;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enc_done_q     <= 1'b0;
      last_grant     <= 1'b1;
      grant_idx      <= 1'b0;
      enc_input_data <= '0;
      enc_cmd        <= '0;
      rsp_data       <= '0;
      rsp_error      <= 1'b0;
    end else begin
      enc_done_q <= enc_done;
      unique case (state)
        IDLE: begin
          if (arb_valid) begin
            grant_idx      <= arb_idx;
            enc_input_data <= arb_idx ? req1_data : req0_data;
            enc_cmd        <= arb_idx ? req1_cmd : req0_cmd;
          end
        end
        WAIT: begin
          // A real completion beats a same-cycle expiry.
          if (done_rise) begin
            rsp_data  <= enc_output_data;
            rsp_error <= 1'b0;
          end else if (tmo_hit) begin
            rsp_data  <= '0;
            rsp_error <= 1'b1;
          end
        end
        DONE: last_grant <= grant_idx;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ble_encoder_arbiter.sv
// Directed bench for ble_encoder_arbiter with a small
// encoder model and hand-computed expectations.
module tb_ble_encoder_arbiter;
  import ble_arb_pkg::*;

  logic         clk;
  logic         reset;
  logic         req0;
  logic [31:0]  req0_data;
  logic [3:0]   req0_cmd;
  logic         req1;
  logic [31:0]  req1_data;
  logic [3:0]   req1_cmd;
  logic         done0;
  logic         done1;
  logic [143:0] rsp_data;
  logic         rsp_error;
  logic         busy;
  logic [31:0]  enc_input_data;
  logic [3:0]   enc_cmd;
  logic         enc_start;
  logic         enc_done;
  logic [143:0] enc_output_data;

  int errors = 0;
  int checks = 0;
  int ord[8];

  ble_encoder_arbiter #(
    .DATA_W         (32),
    .CMD_W          (4),
    .ENC_W          (144),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req0            (req0),
    .req0_data       (req0_data),
    .req0_cmd        (req0_cmd),
    .req1            (req1),
    .req1_data       (req1_data),
    .req1_cmd        (req1_cmd),
    .done0           (done0),
    .done1           (done1),
    .rsp_data        (rsp_data),
    .rsp_error       (rsp_error),
    .busy            (busy),
    .enc_input_data  (enc_input_data),
    .enc_cmd         (enc_cmd),
    .enc_start       (enc_start),
    .enc_done        (enc_done),
    .enc_output_data (enc_output_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [143:0] enc_fn(input logic [31:0] d);
    return {16'hE5C0, 96'h0, d};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Requester + encoder model. drop=1: reqN falls the
  // cycle after doneN; drop=0: requests stay high.
  task automatic serve(input int want, input int lat,
                       input bit drop, input int max_cyc,
                       output int got);
    int  cnt;
    bit  d0;
    bit  d1;
    logic [143:0] exp;
    cnt = 0;
    d0  = 0;
    d1  = 0;
    got = 0;
    for (int c = 0; c < max_cyc && got < want; c++) begin
      tick;
      if (d0) begin req0 = 0; d0 = 0; end
      if (d1) begin req1 = 0; d1 = 0; end
      enc_done = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          enc_done = 1;
          enc_output_data = enc_fn(enc_input_data);
        end
      end
      if (enc_start) cnt = lat;
      if (done0 | done1) begin
        exp = enc_fn(done1 ? req1_data : req0_data);
        checks++;
        if (rsp_data !== exp)
          $display("FAIL serve_rsp: got %h want %h",
                   rsp_data, exp);
        if (rsp_data !== exp) errors++;
        if (got < 8) ord[got] = done1 ? 1 : 0;
        got++;
        if (drop) begin
          if (done0) d0 = 1;
          if (done1) d1 = 1;
        end
      end
    end
    if (d0 | d1) begin
      tick;
      if (d0) req0 = 0;
      if (d1) req1 = 0;
    end
    enc_done = 0;
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL serve_count: got %0d want %0d", got, want);
    end
  endtask

  task automatic pulse_reset;
    reset = 0;
    tick;
    reset = 1;
    tick;
  endtask

  task automatic test_reset;
    req0 = 0; req1 = 0;
    req0_data = '0; req1_data = '0;
    req0_cmd = '0; req1_cmd = '0;
    enc_done = 0; enc_output_data = '0;
    reset = 0;
    tick;
    checks++;
    if ({done0, done1, busy, enc_start, rsp_error} !== 5'b0) begin
      errors++;
      $display("FAIL rst_ctrl: got %b want 00000",
               {done0, done1, busy, enc_start, rsp_error});
    end
    checks++;
    if (rsp_data !== 144'h0) begin
      errors++;
      $display("FAIL rst_rsp: got %h want 0", rsp_data);
    end
    checks++;
    if ({enc_input_data, enc_cmd} !== 36'h0) begin
      errors++;
      $display("FAIL rst_enc: got %h want 0",
               {enc_input_data, enc_cmd});
    end
    reset = 1;
    tick;
    checks++;
    if (busy !== 1'b0 || enc_start !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle: busy %b start %b want 0 0",
               busy, enc_start);
    end
  endtask

  task automatic test_single;
    bit bad;
    req0_data = 32'h0000_A5A5;
    req0_cmd  = BLE_CMD_TX;
    req0      = 1;
    tick;
    checks++;
    if (enc_start !== 1'b1) begin
      errors++;
      $display("FAIL s_start: got %b want 1", enc_start);
    end
    checks++;
    if (enc_input_data !== 32'h0000_A5A5 || enc_cmd !== 4'h1) begin
      errors++;
      $display("FAIL s_latch: got %h/%h want 0000a5a5/1",
               enc_input_data, enc_cmd);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL s_busy: got %b want 1", busy);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (enc_start !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0)
        bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL s_wait: got stray start/done want none");
    end
    enc_done = 1;
    enc_output_data = 144'hBEEF;
    tick;
    enc_done = 0;
    checks++;
    if (done0 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL s_done: got %b%b want 10", done0, done1);
    end
    checks++;
    if (rsp_data !== 144'hBEEF || rsp_error !== 1'b0) begin
      errors++;
      $display("FAIL s_rsp: got %h/%b want beef/0",
               rsp_data, rsp_error);
    end
    checks++;
    if (enc_input_data !== 32'h0000_A5A5) begin
      errors++;
      $display("FAIL s_stable: got %h want 0000a5a5",
               enc_input_data);
    end
    tick;
    req0 = 0;
    checks++;
    if (done0 !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL s_end: done0 %b busy %b want 0 0",
               done0, busy);
    end
    tick;
    tick;
    checks++;
    if (enc_start !== 1'b0 || busy !== 1'b0 ||
        rsp_data !== 144'hBEEF) begin
      errors++;
      $display("FAIL s_hold: start %b busy %b rsp %h want 0 0 beef",
               enc_start, busy, rsp_data);
    end
  endtask

  task automatic test_tie;
    int got;
    pulse_reset;
    req0_data = 32'h1111_0000; req0_cmd = 4'h1;
    req1_data = 32'h2222_0001; req1_cmd = 4'h2;
    req0 = 1;
    req1 = 1;
    serve(2, 3, 1, 60, got);
    checks++;
    if (ord[0] !== 0) begin
      errors++;
      $display("FAIL tie_first: got %0d want 0", ord[0]);
    end
    checks++;
    if (ord[1] !== 1) begin
      errors++;
      $display("FAIL tie_second: got %0d want 1", ord[1]);
    end
    tick;
    tick;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL tie_idle: got %b want 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int got;
    int exp_ord[4] = '{0, 1, 0, 1};
    pulse_reset;
    req0_data = 32'h3333_0030; req0_cmd = 4'h3;
    req1_data = 32'h4444_0041; req1_cmd = 4'h4;
    req0 = 1;
    req1 = 1;
    serve(4, 2, 0, 100, got);
    tick;
    req0 = 0;
    req1 = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ord[i] !== exp_ord[i]) begin
        errors++;
        $display("FAIL b2b_ord%0d: got %0d want %0d",
                 i, ord[i], exp_ord[i]);
      end
    end
    tick;
    tick;
  endtask

  task automatic test_done_level;
    bit bad;
    enc_done = 1;
    enc_output_data = 144'hDEAD;
    tick;
    req1_data = 32'h5A5A_0001;
    req1_cmd  = 4'h2;
    req1 = 1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (done0 !== 1'b0 || done1 !== 1'b0) bad = 1;
    end
    checks++;
    if (bad || busy !== 1'b1) begin
      errors++;
      $display("FAIL lvl_ignore: stray done or busy %b want 1",
               busy);
    end
    enc_done = 0;
    tick;
    enc_done = 1;
    enc_output_data = 144'h1234;
    tick;
    enc_done = 0;
    checks++;
    if (done1 !== 1'b1 || rsp_data !== 144'h1234) begin
      errors++;
      $display("FAIL lvl_done: done1 %b rsp %h want 1 1234",
               done1, rsp_data);
    end
    tick;
    req1 = 0;
    tick;
  endtask

`ifdef BLE_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int k;
    req0_data = 32'h0000_7777;
    req0_cmd  = 4'h5;
    req0 = 1;
    tick;
    tick;
    k = 0;
    while (done0 !== 1'b1 && k < 40) begin
      tick;
      k++;
    end
    checks++;
    if (k != 16) begin
      errors++;
      $display("FAIL tmo_lat: got %0d want 16", k);
    end
    checks++;
    if (rsp_error !== 1'b1 || rsp_data !== 144'h0) begin
      errors++;
      $display("FAIL tmo_rsp: err %b rsp %h want 1 0",
               rsp_error, rsp_data);
    end
    tick;
    req0 = 0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_idle: got %b want 0", busy);
    end
    tick;
  endtask
`else
  task automatic test_wait_hold;
    bit bad;
    req0_data = 32'h0000_7777;
    req0_cmd  = 4'h5;
    req0 = 1;
    tick;
    tick;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (done0 !== 1'b0 || busy !== 1'b1) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold_wait: done or idle seen want busy");
    end
    enc_done = 1;
    enc_output_data = 144'h77;
    tick;
    enc_done = 0;
    checks++;
    if (done0 !== 1'b1 || rsp_error !== 1'b0 ||
        rsp_data !== 144'h77) begin
      errors++;
      $display("FAIL hold_done: %b %b %h want 1 0 77",
               done0, rsp_error, rsp_data);
    end
    tick;
    req0 = 0;
    tick;
  endtask
`endif

  task automatic test_reset_mid;
    bit bad;
    int got;
    req0_data = 32'h0000_CAFE;
    req0_cmd  = 4'h6;
    req0 = 1;
    tick;
    tick;
    tick;
    reset = 0;
    req0 = 0;
    #1;
    checks++;
    if ({done0, done1, busy, enc_start, rsp_error} !== 5'b0) begin
      errors++;
      $display("FAIL mid_ctrl: got %b want 00000",
               {done0, done1, busy, enc_start, rsp_error});
    end
    checks++;
    if (rsp_data !== 144'h0 || enc_input_data !== 32'h0 ||
        enc_cmd !== 4'h0) begin
      errors++;
      $display("FAIL mid_data: rsp %h in %h cmd %h want 0",
               rsp_data, enc_input_data, enc_cmd);
    end
    tick;
    tick;
    reset = 1;
    enc_done = 1;
    enc_output_data = 144'h99;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      enc_done = 0;
      if (done0 | done1 | enc_start) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL mid_stray: got done/start want none");
    end
    req1_data = 32'h0BAD_F00D;
    req1_cmd  = 4'h7;
    req1 = 1;
    serve(1, 4, 1, 40, got);
    checks++;
    if (ord[0] !== 1) begin
      errors++;
      $display("FAIL mid_fresh: got %0d want 1", ord[0]);
    end
  endtask

  initial begin
    reset = 0;
    test_reset;
    test_single;
    test_tie;
    test_back_to_back;
    test_done_level;
`ifdef BLE_ARB_TIMEOUT_EN
    test_timeout;
`else
    test_wait_hold;
`endif
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
